// File: rtl/lockin_pkg.sv
// Shared types and constants for the dual-phase lock-in demodulator.
// The parameter defaults live here so the top and the reference ROM agree.
package lockin_pkg;

   localparam int DEF_DATA_W   = 32;
   localparam int DEF_REF_W    = 16;
   localparam int DEF_LUT_LOG2 = 10;
   localparam int DEF_ACC_W    = 64;

   localparam int M_MIN = 4;
   localparam int N_MAX = 1 << 24;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } state_t;

   // Index of the highest set bit; for a power of two this is its log2.
   function automatic logic [4:0] msb_index(input logic [31:0] value);
      msb_index = '0;
      for (int i = 0; i < 32; i++) begin
         if (value[i]) msb_index = 5'(i);
      end
   endfunction

endpackage

// File: rtl/lockin_ref_rom.sv
// Full-period sine table with two registered read ports (sin and cos taps).
// Contents are fixed at elaboration: round(amp * sin(2*pi*i/depth)).
module lockin_ref_rom
   import lockin_pkg::*;
#(
   parameter int REF_W    = DEF_REF_W,
   parameter int LUT_LOG2 = DEF_LUT_LOG2
) (
   input  logic                       clk,
   input  logic [LUT_LOG2-1:0]        addr_a,
   input  logic [LUT_LOG2-1:0]        addr_b,
   output logic signed [REF_W-1:0]    data_a,
   output logic signed [REF_W-1:0]    data_b
);

   localparam int  DEPTH  = 1 << LUT_LOG2;
   localparam real AMP    = real'((1 << (REF_W - 1)) - 1);
   localparam real TWO_PI = 6.283185307179586;

   logic signed [REF_W-1:0] sine_tab [DEPTH];

   for (genvar i = 0; i < DEPTH; i++) begin : g_tab
      localparam int VAL = int'(AMP * $sin(TWO_PI * real'(i) / real'(DEPTH)));
      assign sine_tab[i] = REF_W'(VAL);
   end

   // NOTE: ROM read registers carry no reset; downstream valid flags qualify them.
   always_ff @(posedge clk) begin
      data_a <= sine_tab[addr_a];
      data_b <= sine_tab[addr_b];
   end

endmodule

// File: rtl/lockin_demod_accum.sv
// Dual-phase lock-in core: multiplies each accepted sample by sin/cos references
// of M points per period and accumulates N periods into I/Q sums.
module lockin_demod_accum
   import lockin_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int REF_W    = DEF_REF_W,
   parameter int LUT_LOG2 = DEF_LUT_LOG2,
   parameter int ACC_W    = DEF_ACC_W
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enable_gral,
   input  logic signed [DATA_W-1:0] data_in,
   input  logic                     data_in_valid,
   input  logic [31:0]              parameter_in_0,
   input  logic [31:0]              parameter_in_1,
   output logic [ACC_W-1:0]         data_out1,
   output logic                     data_out1_valid,
   output logic [ACC_W-1:0]         data_out2,
   output logic                     data_out2_valid,
   output logic                     ready_to_calculate,
   output logic                     processing_finished
);

   localparam int PROD_W = DATA_W + REF_W;
   localparam int DEPTH  = 1 << LUT_LOG2;
   localparam int SH_W   = $clog2(LUT_LOG2 + 1);
   localparam logic [LUT_LOG2-1:0] QUARTER = LUT_LOG2'(DEPTH / 4);

   state_t                    state;
   logic                      enable_q;
   logic [LUT_LOG2-1:0]       m_last;
   logic [24:0]               n_reg;
   logic [24:0]               p;
   logic [LUT_LOG2-1:0]       k;
   logic [SH_W-1:0]           shift;

   logic                      params_legal;
   logic [SH_W-1:0]           shift_next;
   logic                      accept;
   logic [LUT_LOG2-1:0]       sin_addr;
   logic [LUT_LOG2-1:0]       cos_addr;

   logic                      valid_s1;
   logic                      valid_s2;
   logic signed [DATA_W-1:0]  sample_s1;
   logic signed [REF_W-1:0]   sin_q;
   logic signed [REF_W-1:0]   cos_q;
   logic signed [PROD_W-1:0]  prod_i;
   logic signed [PROD_W-1:0]  prod_q;
   logic signed [ACC_W-1:0]   acc_i;
   logic signed [ACC_W-1:0]   acc_q;
   logic                      out_valid;

   always_comb begin
      params_legal = ((parameter_in_0 & (parameter_in_0 - 32'd1)) == 32'd0)
                  && (parameter_in_0 >= 32'(M_MIN))
                  && (parameter_in_0 <= 32'(DEPTH))
                  && (parameter_in_1 != 32'd0)
                  && (parameter_in_1 <= 32'(N_MAX));
      shift_next   = SH_W'(LUT_LOG2 - int'(msb_index(parameter_in_0)));
      accept       = (state == ST_RUN) && enable_gral && data_in_valid;
      sin_addr     = k << shift;
      cos_addr     = sin_addr + QUARTER;
   end

   lockin_ref_rom #(
      .REF_W    (REF_W),
      .LUT_LOG2 (LUT_LOG2)
   ) u_rom (
      .clk    (clk),
      .addr_a (sin_addr),
      .addr_b (cos_addr),
      .data_a (sin_q),
      .data_b (cos_q)
   );

   // Reference phase follows the accepted-sample count, so gaps never move k.
   always_ff @(posedge clk) begin
      if (reset) begin
         state              <= ST_IDLE;
         enable_q           <= 1'b0;
         ready_to_calculate <= 1'b0;
         m_last             <= '0;
         n_reg              <= '0;
         p                  <= '0;
         k                  <= '0;
         shift              <= '0;
         valid_s1           <= 1'b0;
         valid_s2           <= 1'b0;
         sample_s1          <= '0;
         prod_i             <= '0;
         prod_q             <= '0;
         acc_i              <= '0;
         acc_q              <= '0;
         data_out1          <= '0;
         data_out2          <= '0;
         out_valid          <= 1'b0;
      end else begin
         enable_q           <= enable_gral;
         ready_to_calculate <= (state == ST_IDLE) && params_legal;
         valid_s1           <= accept;
         sample_s1          <= data_in;
         valid_s2           <= valid_s1;
         prod_i             <= PROD_W'(sample_s1) * PROD_W'(sin_q);
         prod_q             <= PROD_W'(sample_s1) * PROD_W'(cos_q);
         out_valid          <= 1'b0;
         if (valid_s2) begin
            acc_i <= acc_i + ACC_W'(prod_i);
            acc_q <= acc_q + ACC_W'(prod_q);
         end

         case (state)
            ST_IDLE: begin
               if (enable_gral && !enable_q && ready_to_calculate) begin
                  state  <= ST_RUN;
                  m_last <= LUT_LOG2'(parameter_in_0 - 32'd1);
                  n_reg  <= parameter_in_1[24:0];
                  shift  <= shift_next;
                  k      <= '0;
                  p      <= '0;
                  acc_i  <= '0;
                  acc_q  <= '0;
               end
            end
            ST_RUN: begin
               if (!enable_gral) begin
                  state    <= ST_IDLE;
                  valid_s1 <= 1'b0;
                  valid_s2 <= 1'b0;
               end else if (data_in_valid) begin
                  if (k == m_last) begin
                     k <= '0;
                     p <= p + 25'd1;
                     if (p + 25'd1 == n_reg) state <= ST_DRAIN;
                  end else begin
                     k <= k + 1'b1;
                  end
               end
            end
            ST_DRAIN: begin
               if (!enable_gral) begin
                  state    <= ST_IDLE;
                  valid_s1 <= 1'b0;
                  valid_s2 <= 1'b0;
               end else if (out_valid) begin
                  state <= ST_DONE;
               end else if (!valid_s1 && !valid_s2) begin
                  data_out1 <= acc_i;
                  data_out2 <= acc_q;
                  out_valid <= 1'b1;
               end
            end
            ST_DONE: begin
               if (!enable_gral) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign data_out1_valid     = out_valid;
   assign data_out2_valid     = out_valid;
   assign processing_finished = (state == ST_DONE);

endmodule
